// File: rtl/wb_regbank_stage_pkg.sv
// Shared constants for the write-back register bank and its debug dump engine.
// Default widths are also used by the MEM/WB pipeline latches.
package wb_regbank_stage_pkg;

    localparam int unsigned DEF_SIZE_DATA = 8;
    localparam int unsigned DEF_SIZE_ADDR = 5;
    localparam int unsigned DEF_NUM_REGS  = 32;

    localparam int unsigned REG_ZERO = 0;

    localparam logic [1:0] DUMP_IDLE = 2'd0;
    localparam logic [1:0] DUMP_LOAD = 2'd1;
    localparam logic [1:0] DUMP_SEND = 2'd2;
    localparam logic [1:0] DUMP_DONE = 2'd3;

endpackage

// File: rtl/wb_dump_fsm.sv
// Debug dump engine: walks the register bank in index order, one beat per LOAD/SEND pair.
//
// state | meaning
// IDLE  | waiting for i_dump_start
// LOAD  | capture reg[index] and index into the beat registers
// SEND  | beat valid, wait for consumer ready
// DONE  | one-cycle completion pulse
module wb_dump_fsm
    import wb_regbank_stage_pkg::*;
#(
    parameter int unsigned SIZE_DATA = DEF_SIZE_DATA,
    parameter int unsigned SIZE_ADDR = DEF_SIZE_ADDR,
    parameter int unsigned NUM_REGS  = DEF_NUM_REGS
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_dump_start,
    input  logic                 i_dump_ready,
    output logic [SIZE_ADDR-1:0] o_rd_addr,
    input  logic [SIZE_DATA-1:0] i_rd_data,
    output logic                 o_dump_valid,
    output logic [SIZE_ADDR-1:0] o_dump_addr,
    output logic [SIZE_DATA-1:0] o_dump_data,
    output logic                 o_dump_busy,
    output logic                 o_dump_done
);

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [SIZE_ADDR-1:0] index;
    logic                 last_beat;

    assign last_beat = (32'(index) == NUM_REGS - 1);
    assign o_rd_addr = index;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= DUMP_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Beat registers hold a private copy so a stalled beat is immune to later writes.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            index       <= '0;
            o_dump_addr <= '0;
            o_dump_data <= '0;
        end else begin
            case (state)
                DUMP_IDLE: if (i_dump_start) index <= '0;
                DUMP_LOAD: begin
                    o_dump_data <= i_rd_data;
                    o_dump_addr <= index;
                end
                DUMP_SEND: if (i_dump_ready && !last_beat) index <= index + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DUMP_IDLE: if (i_dump_start) state_next = DUMP_LOAD;
            DUMP_LOAD: state_next = DUMP_SEND;
            DUMP_SEND: if (i_dump_ready) state_next = last_beat ? DUMP_DONE : DUMP_LOAD;
            DUMP_DONE: state_next = DUMP_IDLE;
            default:   state_next = DUMP_IDLE;
        endcase
    end

    always_comb begin
        o_dump_valid = (state == DUMP_SEND);
        o_dump_busy  = (state != DUMP_IDLE);
        o_dump_done  = (state == DUMP_DONE);
    end

endmodule

// File: rtl/wb_regbank_stage.sv
// Write-back stage: selects the WB value, commits it to the register bank, serves ID reads.
// Optional WB_WRITE_BYPASS_EN makes the read ports (and dump capture) see the in-flight write.
module wb_regbank_stage
    import wb_regbank_stage_pkg::*;
#(
    parameter int unsigned SIZE_DATA = DEF_SIZE_DATA,
    parameter int unsigned SIZE_ADDR = DEF_SIZE_ADDR,
    parameter int unsigned NUM_REGS  = DEF_NUM_REGS
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_reg_write,
    input  logic                 i_mem_to_reg,
    input  logic [SIZE_ADDR-1:0] i_rd,
    input  logic [SIZE_DATA-1:0] i_mem_data,
    input  logic [SIZE_DATA-1:0] i_alu_result,
    input  logic [SIZE_ADDR-1:0] i_rs_addr,
    input  logic [SIZE_ADDR-1:0] i_rt_addr,
    output logic [SIZE_DATA-1:0] o_rs_data,
    output logic [SIZE_DATA-1:0] o_rt_data,
    output logic                 o_wb_write,
    output logic [SIZE_ADDR-1:0] o_wb_rd,
    output logic [SIZE_DATA-1:0] o_wb_data,
    input  logic                 i_dump_start,
    input  logic                 i_dump_ready,
    output logic                 o_dump_valid,
    output logic [SIZE_ADDR-1:0] o_dump_addr,
    output logic [SIZE_DATA-1:0] o_dump_data,
    output logic                 o_dump_busy,
    output logic                 o_dump_done
);

    logic [SIZE_DATA-1:0] regs [NUM_REGS];
    logic [SIZE_ADDR-1:0] dump_rd_addr;
    logic [SIZE_DATA-1:0] dump_rd_data;

    assign o_wb_data  = i_mem_to_reg ? i_mem_data : i_alu_result;
    assign o_wb_write = i_enable & i_reg_write & (i_rd != SIZE_ADDR'(REG_ZERO));
    assign o_wb_rd    = i_rd;

    function automatic logic in_bank(input logic [SIZE_ADDR-1:0] addr);
        return (addr != SIZE_ADDR'(REG_ZERO)) && (32'(addr) < NUM_REGS);
    endfunction

    function automatic logic [SIZE_DATA-1:0] read_port(input logic [SIZE_ADDR-1:0] addr);
        logic [SIZE_DATA-1:0] value;
        value = '0;
        if (in_bank(addr)) value = regs[addr];
`ifdef WB_WRITE_BYPASS_EN
        if (o_wb_write && in_bank(addr) && (addr == i_rd)) value = o_wb_data;
`endif
        return value;
    endfunction

    assign o_rs_data    = read_port(i_rs_addr);
    assign o_rt_data    = read_port(i_rt_addr);
    assign dump_rd_data = read_port(dump_rd_addr);

    // Entry 0 is never written, so the hardwired-zero read falls out of reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
        end else if (o_wb_write && in_bank(i_rd)) begin
            regs[i_rd] <= o_wb_data;
        end
    end

    wb_dump_fsm #(
        .SIZE_DATA (SIZE_DATA),
        .SIZE_ADDR (SIZE_ADDR),
        .NUM_REGS  (NUM_REGS)
    ) u_dump_fsm (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_rd_addr    (dump_rd_addr),
        .i_rd_data    (dump_rd_data),
        .o_dump_valid (o_dump_valid),
        .o_dump_addr  (o_dump_addr),
        .o_dump_data  (o_dump_data),
        .o_dump_busy  (o_dump_busy),
        .o_dump_done  (o_dump_done)
    );

endmodule

// File: doc/wb_regbank_stage.md
Name: wb_regbank_stage

Overview:
- Write-back end of the MEM/WB interface. It consumes the latched MEM/WB fields and selects the write-back value (memory data or ALU result).
- It commits that value into the architectural register bank and serves the two ID-stage read ports.
- It also exposes the committed write to the forwarding unit.
- A debug dump engine streams every register, in index order, over a valid/ready handshake to the debug unit.

Parameters:
- SIZE_DATA, 8, register and data width in bits.
- SIZE_ADDR, 5, register index width.
- NUM_REGS, 32, register count; must be at most 2**SIZE_ADDR.

Ports:
- i_clk  in  1  single system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  pipeline advance; write-back commits only when high.
- i_reg_write  in  1  MEM/WB control: write enable.
- i_mem_to_reg  in  1  MEM/WB control: 1 selects memory data, 0 selects ALU result.
- i_rd  in  SIZE_ADDR  destination register index.
- i_mem_data  in  SIZE_DATA  loaded memory value.
- i_alu_result  in  SIZE_DATA  ALU result.
- i_rs_addr, i_rt_addr  in  SIZE_ADDR  read-port indices.
- o_rs_data, o_rt_data  out  SIZE_DATA  read-port data.
- o_wb_write  out  1  write-back commits this cycle (forwarding).
- o_wb_rd  out  SIZE_ADDR  forwarding destination index.
- o_wb_data  out  SIZE_DATA  selected write-back value.
- i_dump_start  in  1  one-cycle pulse that starts a dump.
- i_dump_ready  in  1  consumer ready.
- o_dump_valid  out  1  dump beat valid.
- o_dump_addr  out  SIZE_ADDR  index of the current beat.
- o_dump_data  out  SIZE_DATA  value of the current beat.
- o_dump_busy  out  1  FSM is not IDLE.
- o_dump_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (i_reset low, asynchronous):
  - All registers clear to 0.
  - FSM goes to IDLE.
  - o_dump_valid, o_dump_busy, o_dump_done, o_dump_addr and o_dump_data are 0.
- Write-back value: o_wb_data = i_mem_to_reg ? i_mem_data : i_alu_result. Combinational, zero latency.
- o_wb_write = i_enable & i_reg_write & (i_rd != 0); o_wb_rd = i_rd.
- Commit: register i_rd takes o_wb_data at the rising edge when o_wb_write is high.
- Register 0 reads 0 always; writes to it are dropped.
- Indices at or above NUM_REGS: reads return 0; writes are dropped.
- Read ports are combinational, from the register contents (bypass per Optional Feature).
- Dump FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE to LOAD on i_dump_start; the index counter clears to 0.
  - LOAD (1 cycle): captures reg[index] into o_dump_data and index into o_dump_addr, then goes to SEND.
  - SEND: o_dump_valid is high.
    - On valid & ready with index < NUM_REGS-1: index increments, go to LOAD.
    - On valid & ready with index = NUM_REGS-1: go to DONE.
    - While ready is low: hold; o_dump_data and o_dump_addr are stable even if that register is written meanwhile (captured copy).
  - DONE (1 cycle): o_dump_done pulses high, then IDLE.
- Throughput is one beat per 2 cycles; a full dump with ready held high takes 2*NUM_REGS+1 cycles from start to done.
- i_dump_start is ignored unless the FSM is IDLE.
- Write-back is never stalled by a dump; each beat reflects contents at its LOAD cycle.
- Reset during a dump aborts it immediately; no done pulse is produced.

Optional Feature:
- Macro WB_WRITE_BYPASS_EN.
- Defined: if o_wb_write is high and a read index equals i_rd, that read port returns o_wb_data in the same cycle (write-through, so ID sees the value WB is writing). The bypass applies to the read ports only; dump LOAD also captures the bypassed value.
- Undefined: read ports and LOAD return the stored value; the new value is visible from the next cycle.

Decomposition:
- Shared package:
  - localparams for the dump FSM state encoding (2-bit).
  - REG_ZERO index constant.
  - default SIZE_DATA/SIZE_ADDR/NUM_REGS constants, shared with the pipeline latches.
- One sub-module is natural: wb_dump_fsm, holding the FSM, the index counter and the captured beat. It takes a read address/data pair into the bank as its only coupling.

Test Plan:
- Reset low mid-activity, then release -> all reads 0, o_dump_valid=0, o_dump_busy=0.
- enable=1, reg_write=1, mem_to_reg=0, rd=5, alu=0x3C, mem=0xA1 -> next cycle rs_addr=5 reads 0x3C; with mem_to_reg=1, reads 0xA1.
- Write rd=0, value 0xFF -> reg 0 reads 0; o_wb_write=0. Write with enable=0 -> no change.
- Same-cycle write rd=7=0x55 with rs_addr=7, old value 0x11 -> o_rs_data=0x55 if WB_WRITE_BYPASS_EN is defined, else 0x11.
- Regs preloaded reg[i]=i+1, dump start, ready held 1 -> beats addr 0..31 carry 0,2,3..32 (reg 0 reads 0); done pulses at cycle 65; busy is low afterwards.
- Ready low for 10 cycles at beat 3 while reg 3 is written 0xEE -> beat holds its original value; beat 3 is not repeated after ready rises; a second i_dump_start during the dump is ignored.
